// File: rtl/life_run_controller.sv
// Game of Life run sequencer: debounces the four user buttons and issues a
// single-cycle run strobe aligned to frame_end at a selectable speed.
module life_run_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SPEED_MAX       = 7,
  parameter int SPEED_DEFAULT   = 3,
  parameter bit START_RUNNING   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  button,
  input  logic        frame_end,
  output logic        run,
  output logic        running,
  output logic [2:0]  speed,
  output logic [15:0] generation_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = SPEED_MAX + 1;

  typedef enum logic [1:0] {PAUSED, RUNNING, STEP_WAIT} state_t;

  state_t        state, state_next;
  logic [3:0]    sync1, sync2, level, press;
  logic [DW-1:0] db_cnt [4];
  logic [FW-1:0] frame_cnt, frame_cnt_next, period_last;
  logic          period_done, run_next;
  logic          speed_up, speed_dn, speed_chg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // A press is flagged in the same edge the debounced level rises, so the
  // FSM reacts DEBOUNCE_CYCLES+3 edges after a stable raw transition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      press <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    speed_up    = press[2] && !press[3] && (speed != 3'(SPEED_MAX));
    speed_dn    = press[3] && !press[2] && (speed != '0);
    speed_chg   = speed_up || speed_dn;
    period_last = (FW'(1) << (SPEED_MAX - int'(speed))) - FW'(1);
    period_done = frame_end && (frame_cnt == period_last);
  end

  always_comb begin
    state_next = state;
    run_next   = 1'b0;
    case (state)
      RUNNING: begin
        run_next = period_done;
        if (press[0]) state_next = PAUSED;
      end
      PAUSED: begin
        if (press[0])      state_next = RUNNING;
        else if (press[1]) state_next = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (frame_end) begin
          run_next   = 1'b1;
          state_next = PAUSED;
        end
      end
      default: state_next = PAUSED;
    endcase
    run_next = run_next && !run;

    frame_cnt_next = frame_cnt;
    if (state != RUNNING || state_next != RUNNING || speed_chg) frame_cnt_next = '0;
    else if (period_done)                                      frame_cnt_next = '0;
    else if (frame_end)                                        frame_cnt_next = frame_cnt + FW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= START_RUNNING ? RUNNING : PAUSED;
      run              <= 1'b0;
      speed            <= 3'(SPEED_DEFAULT);
      frame_cnt        <= '0;
      generation_count <= '0;
    end else begin
      state     <= state_next;
      run       <= run_next;
      frame_cnt <= frame_cnt_next;
      if (speed_up)      speed <= speed + 3'(1);
      else if (speed_dn) speed <= speed - 3'(1);
      if (run) generation_count <= generation_count + 16'(1);
    end
  end

  assign running = (state == RUNNING);

endmodule

// File: tb/tb_life_run_controller.sv
// Bench for life_run_controller: a behavioural model compared every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_life_run_controller;

  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  button = '0;
  logic        frame_end = 1'b0;
  logic        run, running;
  logic [2:0]  speed;
  logic [15:0] generation_count;

  int checks = 0;
  int errors = 0;

  life_run_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .SPEED_MAX(7),
    .SPEED_DEFAULT(3),
    .START_RUNNING(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button(button),
    .frame_end(frame_end),
    .run(run),
    .running(running),
    .speed(speed),
    .generation_count(generation_count)
  );

  always #5 clock = ~clock;

  // frame_end: one cycle in every 100, independent of reset
  int cyc = 0;
  int fe_total = 0;
  bit fe_en = 1'b0;
  initial forever begin
    @(posedge clock);
    cyc++;
    if (fe_en && (cyc % 100 == 0)) begin
      fe_total++;
      #1 frame_end = 1'b1;
    end else begin
      #1 frame_end = 1'b0;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: buttons are judged from a history of raw samples,
  // the controller by a mode plus a count of frames in the current period.
  typedef enum int {M_PAUSED, M_RUNNING, M_STEP} mmode_t;
  logic [3:0]  hist[$];
  logic [3:0]  m_level, m_press, p, hv;
  int          m_speed, m_frames, period;
  mmode_t      m_mode = M_RUNNING;
  bit          m_run, emit, chg, agree;
  logic [15:0] m_gen = '0;
  logic [15:0] gen_bias = '0;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      hist.delete();
      for (int j = 0; j < DEB + 2; j++) hist.push_back(4'b0);
      m_level = '0; m_press = '0; m_speed = 3; m_frames = 0;
      m_mode = M_RUNNING; m_run = 1'b0; m_gen = '0;
    end else begin
      p = m_press; emit = 1'b0; chg = 1'b0;
      if (m_run) m_gen = m_gen + 16'd1;
      period = 1 << (7 - m_speed);
      if (p[2] && !p[3] && m_speed < 7) begin m_speed++; chg = 1'b1; end
      else if (p[3] && !p[2] && m_speed > 0) begin m_speed--; chg = 1'b1; end
      case (m_mode)
        M_RUNNING: begin
          if (frame_end) begin
            m_frames++;
            if (m_frames == period) begin emit = 1'b1; m_frames = 0; end
          end
          if (p[0]) begin m_mode = M_PAUSED; m_frames = 0; end
          if (chg) m_frames = 0;
        end
        M_PAUSED: begin
          if (p[0]) m_mode = M_RUNNING;
          else if (p[1]) m_mode = M_STEP;
        end
        default: if (frame_end) begin emit = 1'b1; m_mode = M_PAUSED; end
      endcase
      m_run = emit;
      // raw sample k-2 is the newest one the debouncer can have seen
      hist.push_front(button);
      void'(hist.pop_back());
      m_press = '0;
      for (int b = 0; b < 4; b++) begin
        agree = 1'b0;
        for (int j = 2; j < DEB + 2; j++) begin
          hv = hist[j];
          if (hv[b] == m_level[b]) agree = 1'b1;
        end
        if (!agree) begin
          m_level[b] = ~m_level[b];
          m_press[b] = m_level[b];
        end
      end
    end
  end

  always @(negedge clock) begin
    check("run", run, m_run);
    check("running", running, (m_mode == M_RUNNING));
    check("speed", speed, m_speed);
    check("generation_count", generation_count, 16'(m_gen + gen_bias));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_frames(input int n);
    int target;
    int guard;
    target = fe_total + n;
    guard  = 0;
    while (fe_total < target && guard < 110 * n + 200) begin
      tick(1);
      guard++;
    end
    if (fe_total < target) begin
      checks++;
      errors++;
      $display("FAIL frame_wait: got %0d frames expected %0d", fe_total, target);
    end
  endtask

  task automatic sync_frame();
    wait_frames(1);
    tick(2);
  endtask

  task automatic press(input logic [3:0] mask);
    button = button | mask;
    tick(10);
    button = button & ~mask;
    tick(10);
  endtask

  logic [15:0] g_before;

  initial begin
    tick(3);
    check("reset_run", run, 0);
    check("reset_running", running, 1);
    check("reset_speed", speed, 3);
    check("reset_gen", generation_count, 0);
    reset = 1'b0;
    fe_en = 1'b1;

    // free run at period 16
    wait_frames(40);
    tick(2);
    check("gen_after_40", generation_count, 2);

    // glitch then stable play press
    sync_frame();
    button[0] = 1'b1; tick(2);
    button[0] = 1'b0; tick(1);
    button[0] = 1'b1; tick(6);
    check("not_yet_paused", running, 1);
    tick(1);
    check("paused_at_7", running, 0);
    tick(3);
    button[0] = 1'b0;
    tick(10);
    wait_frames(50);
    tick(2);
    check("no_run_paused", generation_count, 2);

    // single step, second step press swallowed in STEP_WAIT
    sync_frame();
    press(4'b0010);
    press(4'b0010);
    wait_frames(1);
    tick(2);
    check("step_gen", generation_count, 3);
    check("step_back_paused", running, 0);
    wait_frames(2);
    tick(2);
    check("step_once", generation_count, 3);

    // speed saturation
    for (int i = 0; i < 6; i++) press(4'b0100);
    check("speed_max", speed, 7);
    sync_frame();
    press(4'b0001);
    wait_frames(3);
    tick(2);
    check("period_1", generation_count, 6);
    sync_frame();
    press(4'b0001);
    for (int i = 0; i < 9; i++) press(4'b1000);
    check("speed_min", speed, 0);
    press(4'b0100);
    press(4'b1100);
    check("speed_both", speed, 1);
    press(4'b1000);
    check("speed_zero", speed, 0);
    sync_frame();
    press(4'b0001);
    wait_frames(127);
    tick(2);
    check("period_128_early", generation_count, 7);
    wait_frames(1);
    tick(2);
    check("period_128", generation_count, 8);

    // play press lands with the period-completing frame_end
    for (int i = 0; i < 7; i++) press(4'b0100);
    check("speed_back_max", speed, 7);
    for (int g = 0; g < 200 && (cyc % 100) != 94; g++) tick(1);
    g_before = 16'(m_gen + gen_bias);
    button[0] = 1'b1;
    tick(10);
    button[0] = 1'b0;
    tick(10);
    check("pause_on_frame", running, 0);
    check("run_on_pause", generation_count, 16'(g_before + 16'd1));
    press(4'b0011);
    check("play_beats_step", running, 1);

    // asynchronous reset while in STEP_WAIT
    sync_frame();
    press(4'b0001);
    press(4'b0010);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset_run", run, 0);
    check("areset_gen", generation_count, 0);
    check("areset_running", running, 1);
    check("areset_speed", speed, 3);
    wait_frames(1);
    tick(3);
    reset = 1'b0;
    tick(5);
    check("post_reset_gen", generation_count, 0);

    // generation_count wrap
    sync_frame();
    press(4'b0001);
    force dut.generation_count = 16'hFFFF;
    #1;
    release dut.generation_count;
    gen_bias = 16'hFFFF - m_gen;
    tick(1);
    check("preload", generation_count, 16'hFFFF);
    press(4'b0010);
    wait_frames(1);
    tick(2);
    check("wrap", generation_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
